// File: rtl/vdc_pkg.sv
// Shared VDC RAM arbiter types: slot owner encoding and the owner pipeline entry.
package vdc_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_RFSH = 2'd2,
    OWN_CPU  = 2'd3
  } vdc_owner_t;

  typedef struct packed {
    vdc_owner_t owner;
    logic       we;
  } vdc_slot_t;

  localparam vdc_slot_t SlotIdle = '{owner: OWN_NONE, we: 1'b0};

  // Only reads return data to a requester; refresh data is discarded.
  function automatic logic slot_returns_data(input vdc_slot_t s, input vdc_owner_t who);
    return (s.owner == who) && !s.we;
  endfunction

endpackage

// File: rtl/vdc_ram_arbiter.sv
// Single-port VDC video RAM arbiter: display fetch, DRAM refresh and CPU share one slot per
// enable tick, fixed priority with a CPU starvation guard, 2-tick pipelined read return.
module vdc_ram_arbiter
  import vdc_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned ADDR_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              hblank,
  input  logic              line_start,
  input  logic [3:0]        reg_refresh,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_grant,
  output logic              disp_valid,
  output logic [7:0]        disp_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_di,
  output logic              cpu_grant,
  output logic              cpu_valid,
  output logic [7:0]        cpu_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_di,
  input  logic [7:0]        ram_do
);

  localparam logic [7:0] StarveMax = 8'(STARVE_LIMIT);

  vdc_owner_t        owner;
  vdc_slot_t         slot_a_q, slot_b_q, slot_a_d;
  logic [3:0]        rfsh_owed_q, rfsh_owed_d;
  logic [7:0]        rfsh_addr_q, rfsh_addr_d;
  logic [7:0]        starve_q, starve_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [7:0]        ram_di_q, ram_di_d;
  logic              disp_grant_q, cpu_grant_q;
  logic              disp_valid_q, cpu_valid_q;
  logic [7:0]        disp_data_q, cpu_rdata_q;

  // Slot owner for this tick.
  always_comb begin
    owner = OWN_NONE;
    if (cpu_req && (starve_q == StarveMax)) begin
      owner = OWN_CPU;
    end else if (disp_req) begin
      owner = OWN_DISP;
    end else if (hblank && (rfsh_owed_q != 4'd0)) begin
      owner = OWN_RFSH;
    end else if (cpu_req) begin
      owner = OWN_CPU;
    end
  end

  // Refresh quota/address and CPU starvation counter.
  always_comb begin
    rfsh_owed_d = rfsh_owed_q;
    rfsh_addr_d = rfsh_addr_q;
    starve_d    = starve_q;
    if (owner == OWN_RFSH) begin
      rfsh_owed_d = rfsh_owed_q - 4'd1;
      rfsh_addr_d = rfsh_addr_q + 8'd1;
    end
    // A new line's quota overrides any decrement in the same tick.
    if (line_start) begin
      rfsh_owed_d = reg_refresh;
    end
    if (!cpu_req || (owner == OWN_CPU)) begin
      starve_d = 8'd0;
    end else if (starve_q != StarveMax) begin
      starve_d = starve_q + 8'd1;
    end
  end

  // RAM port drive for the granted slot; an idle slot leaves the address alone.
  always_comb begin
    ram_addr_d = ram_addr_q;
    ram_we_d   = 1'b0;
    ram_di_d   = ram_di_q;
    slot_a_d   = '{owner: owner, we: (owner == OWN_CPU) && cpu_we};
    unique case (owner)
      OWN_DISP: ram_addr_d = disp_addr;
      OWN_RFSH: ram_addr_d = ADDR_W'(rfsh_addr_q);
      OWN_CPU: begin
        ram_addr_d = cpu_addr;
        ram_we_d   = cpu_we;
        if (cpu_we) begin
          ram_di_d = cpu_di;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_a_q     <= SlotIdle;
      slot_b_q     <= SlotIdle;
      rfsh_owed_q  <= 4'd0;
      rfsh_addr_q  <= 8'd0;
      starve_q     <= 8'd0;
      ram_addr_q   <= '0;
      ram_we_q     <= 1'b0;
      ram_di_q     <= 8'd0;
      disp_grant_q <= 1'b0;
      cpu_grant_q  <= 1'b0;
      disp_valid_q <= 1'b0;
      cpu_valid_q  <= 1'b0;
      disp_data_q  <= 8'd0;
      cpu_rdata_q  <= 8'd0;
    end else if (enable) begin
      slot_a_q     <= slot_a_d;
      slot_b_q     <= slot_a_q;
      rfsh_owed_q  <= rfsh_owed_d;
      rfsh_addr_q  <= rfsh_addr_d;
      starve_q     <= starve_d;
      ram_addr_q   <= ram_addr_d;
      ram_we_q     <= ram_we_d;
      ram_di_q     <= ram_di_d;
      disp_grant_q <= (owner == OWN_DISP);
      cpu_grant_q  <= (owner == OWN_CPU);
      // slot_b lines up with ram_do from the sync RAM.
      disp_valid_q <= slot_returns_data(slot_b_q, OWN_DISP);
      cpu_valid_q  <= slot_returns_data(slot_b_q, OWN_CPU);
      if (slot_returns_data(slot_b_q, OWN_DISP)) begin
        disp_data_q <= ram_do;
      end
      if (slot_returns_data(slot_b_q, OWN_CPU)) begin
        cpu_rdata_q <= ram_do;
      end
    end
  end

  assign disp_grant = disp_grant_q;
  assign disp_valid = disp_valid_q;
  assign disp_data  = disp_data_q;
  assign cpu_grant  = cpu_grant_q;
  assign cpu_valid  = cpu_valid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign ram_addr   = ram_addr_q;
  assign ram_we     = ram_we_q;
  assign ram_di     = ram_di_q;

endmodule

// File: tb/tb_vdc_ram_arbiter.sv
// Self-checking bench for vdc_ram_arbiter: sync RAM model, read-data scoreboards, vector table
// and directed sequences for contention, refresh, wrap, reset and enable stalls.
module tb_vdc_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset, enable, hblank, line_start;
  logic [3:0]  reg_refresh;
  logic        disp_req, disp_grant, disp_valid;
  logic [15:0] disp_addr;
  logic [7:0]  disp_data;
  logic        cpu_req, cpu_we, cpu_grant, cpu_valid;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_di, cpu_rdata;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_di, ram_do;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [0:65535];
  logic [7:0] cpu_q[$];
  logic [7:0] disp_q[$];

  typedef struct {
    logic        disp;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[8];

  vdc_ram_arbiter #(.STARVE_LIMIT(8), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .hblank(hblank), .line_start(line_start),
    .reg_refresh(reg_refresh), .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_grant(disp_grant), .disp_valid(disp_valid), .disp_data(disp_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_di(cpu_di),
    .cpu_grant(cpu_grant), .cpu_valid(cpu_valid), .cpu_rdata(cpu_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_di(ram_di), .ram_do(ram_do)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // Sync RAM, one tick read latency, frozen with enable like the rest of the VDC.
  always @(posedge clk) begin
    if (enable) begin
      if (ram_we) mem[ram_addr] <= ram_di;
      ram_do <= mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A valid pulse is consumed on the last cycle it is shown before an enabled edge.
  always @(negedge clk) begin
    if (!reset && enable) begin
      if (cpu_valid) begin
        if (cpu_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL cpu_valid unexpected: rdata=%0h, expected no pulse", cpu_rdata);
        end else begin
          check("sb cpu_rdata", cpu_rdata, cpu_q.pop_front());
        end
      end
      if (disp_valid) begin
        if (disp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL disp_valid unexpected: data=%0h, expected no pulse", disp_data);
        end else begin
          check("sb disp_data", disp_data, disp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input vec_t v);
    tick();
    if (v.disp) begin
      disp_req = 1'b1; disp_addr = v.addr;
      disp_q.push_back(v.exp);
    end else begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_di = v.data;
      if (!v.we) cpu_q.push_back(v.exp);
    end
    tick();
    check(v.disp ? "txn disp_grant" : "txn cpu_grant", v.disp ? disp_grant : cpu_grant, 1);
    check("txn ram_addr", ram_addr, v.addr);
    check("txn ram_we", ram_we, v.we);
    if (v.we) check("txn ram_di", ram_di, v.data);
    disp_req = 1'b0; cpu_req = 1'b0;
    tick();
    check("txn ram_we one tick", ram_we, 0);
    tick();
    check(v.disp ? "txn disp_valid" : "txn cpu_valid", v.disp ? disp_valid : cpu_valid, !v.we);
    if (!v.we) check("txn rdata", v.disp ? disp_data : cpu_rdata, v.exp);
  endtask

  task automatic pulse_line(input logic [3:0] n);
    tick();
    reg_refresh = n; line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = pat(16'(i));
    mem[16'h1234] = 8'hA5;
    reset = 1'b1; enable = 1'b1; hblank = 1'b0; line_start = 1'b0; reg_refresh = 4'd0;
    disp_req = 1'b0; disp_addr = 16'h0; cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = 16'h0; cpu_di = 8'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("reset cpu_grant", cpu_grant, 0);
    check("reset disp_grant", disp_grant, 0);
    check("reset cpu_valid", cpu_valid, 0);
    check("reset disp_valid", disp_valid, 0);
    check("reset ram_addr", ram_addr, 0);
    check("reset ram_we", ram_we, 0);
    check("reset ram_di", ram_di, 0);

    vecs[0] = '{disp: 1'b0, we: 1'b0, addr: 16'h1234, data: 8'h00, exp: 8'hA5};
    vecs[1] = '{disp: 1'b0, we: 1'b1, addr: 16'h3FFF, data: 8'h5A, exp: 8'h00};
    vecs[2] = '{disp: 1'b0, we: 1'b0, addr: 16'h3FFF, data: 8'h00, exp: 8'h5A};
    vecs[3] = '{disp: 1'b1, we: 1'b0, addr: 16'h0100, data: 8'h00, exp: pat(16'h0100)};
    vecs[4] = '{disp: 1'b0, we: 1'b1, addr: 16'h0100, data: 8'hC3, exp: 8'h00};
    vecs[5] = '{disp: 1'b1, we: 1'b0, addr: 16'h0100, data: 8'h00, exp: 8'hC3};
    vecs[6] = '{disp: 1'b0, we: 1'b0, addr: 16'hFFFF, data: 8'h00, exp: pat(16'hFFFF)};
    vecs[7] = '{disp: 1'b0, we: 1'b0, addr: 16'h0000, data: 8'h00, exp: pat(16'h0000)};
    foreach (vecs[i]) run_txn(vecs[i]);

    // Display and CPU both held: every 9th grant is the starved CPU.
    tick();
    disp_req = 1'b1; disp_addr = 16'h0200;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    for (int i = 1; i <= 20; i++) begin
      if (i % 9 == 0) cpu_q.push_back(8'hA5);
      else disp_q.push_back(pat(16'h0200));
      tick();
      check("contend cpu_grant", cpu_grant, (i % 9 == 0));
      check("contend disp_grant", disp_grant, (i % 9 != 0));
    end
    disp_req = 1'b0; cpu_req = 1'b0;
    repeat (4) tick();

    // Enable low for 3 ticks mid-read delays the valid by 3 ticks.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3FFF;
    cpu_q.push_back(8'h5A);
    tick();
    check("stall cpu_grant", cpu_grant, 1);
    cpu_req = 1'b0;
    tick();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall no early valid", cpu_valid, 0);
    end
    enable = 1'b1;
    tick();
    check("stall cpu_valid", cpu_valid, 1);
    check("stall cpu_rdata", cpu_rdata, 8'h5A);
    tick();
    check("stall valid one tick", cpu_valid, 0);

    // Reset one tick after a read grant kills the in-flight read.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    tick();
    check("rst cpu_grant", cpu_grant, 1);
    cpu_req = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst cpu_grant cleared", cpu_grant, 0);
    check("rst ram_addr", ram_addr, 0);
    check("rst cpu_rdata", cpu_rdata, 0);
    check("rst disp_data", disp_data, 0);
    repeat (3) begin
      tick();
      check("rst no cpu_valid", cpu_valid, 0);
    end

    // Refresh quota of 5: addresses 0..4, then nothing until the next line.
    hblank = 1'b1;
    pulse_line(4'd5);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rfsh ram_addr", ram_addr, (i < 5) ? i : 4);
      check("rfsh ram_we", ram_we, 0);
    end
    pulse_line(4'd1);
    tick();
    check("rfsh next line", ram_addr, 5);
    repeat (3) tick();
    check("rfsh quota 1", ram_addr, 5);

    // 250 more refreshes reach 255, then the address wraps to 0.
    for (int l = 0; l < 25; l++) begin
      pulse_line(4'd10);
      repeat (10) tick();
    end
    check("wrap last addr", ram_addr, 255);
    pulse_line(4'd1);
    tick();
    check("wrap to zero", ram_addr, 0);
    hblank = 1'b0;
    pulse_line(4'd0);
    repeat (5) tick();

    check("cpu sb drained", cpu_q.size(), 0);
    check("disp sb drained", disp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
